// File: rtl/frame_deframer.sv
// Serial symbol deframer: hunts for a 16-bit sync word, then assembles a
// fixed-length frame of bytes with a trailing mod-256 checksum into a 4-deep output FIFO.
module frame_deframer #(
   parameter logic [15:0] SYNC_WORD   = 16'hEB90,
   parameter int unsigned FRAME_BYTES = 8,
   parameter int unsigned IDLE_LIMIT  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] code_in,
   input  logic       code_en,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       byte_last,
   output logic       sync_locked,
   output logic       frame_done,
   output logic       frame_err,
   output logic       overflow
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned ENT_W = 9;
   localparam int unsigned CTR_W = 8;

   localparam logic [0:0] HUNT    = 1'b0;
   localparam logic [0:0] PAYLOAD = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [15:0]      sync_q, sync_d;
   logic [6:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [CTR_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]       csum_q, csum_d;
   logic [CTR_W-1:0] idle_q, idle_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             overflow_q, overflow_d;

   logic             bit_ok;
   logic             bit_val;
   logic             idle_sym;
   logic [7:0]       new_byte;
   logic             push;
   logic             push_ok;
   logic             pop;
   logic [ENT_W-1:0] push_ent;

   assign bit_ok   = code_en && ((code_in == 2'b01) || (code_in == 2'b10));
   assign bit_val  = (code_in == 2'b01);
   assign idle_sym = code_en && !bit_ok;
   assign new_byte = {shift_q, bit_val};
   assign pop      = valid_q && byte_ready;

   // Framing FSM plus FIFO bookkeeping
   always_comb begin
      state_d    = state_q;
      sync_d     = sync_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      csum_d     = csum_q;
      idle_d     = idle_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      push       = 1'b0;
      push_ent   = '0;
      push_ok    = 1'b0;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      head_d     = '0;
      valid_d    = 1'b0;

      case (state_q)
         HUNT: begin
            if (bit_ok) begin
               sync_d = {sync_q[14:0], bit_val};
               if (sync_d == SYNC_WORD) begin
                  // Sync bits are consumed so they cannot seed the next hunt
                  state_d    = PAYLOAD;
                  sync_d     = '0;
                  shift_d    = '0;
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  csum_d     = '0;
                  idle_d     = '0;
               end
            end
         end
         PAYLOAD: begin
            if (bit_ok) begin
               idle_d    = '0;
               shift_d   = new_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  push       = 1'b1;
                  byte_cnt_d = byte_cnt_q + CTR_W'(1);
                  if (byte_cnt_q == CTR_W'(FRAME_BYTES - 1)) begin
                     push_ent = {1'b1, new_byte};
                     done_d   = 1'b1;
                     err_d    = (new_byte != csum_q);
                     state_d  = HUNT;
                  end else begin
                     push_ent = {1'b0, new_byte};
                     csum_d   = csum_q + new_byte;
                  end
               end
            end else if (idle_sym) begin
               idle_d = idle_q + CTR_W'(1);
               if (idle_d == CTR_W'(IDLE_LIMIT)) begin
                  done_d    = 1'b1;
                  err_d     = 1'b1;
                  shift_d   = '0;
                  bit_cnt_d = '0;
                  state_d   = HUNT;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
         // A simultaneous pop frees a slot even when full
         if ((count_q != CNT_W'(DEPTH)) || pop) begin
            push_ok         = 1'b1;
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      valid_d = (count_d != '0);
      if (valid_d) begin
         head_d = mem_d[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         sync_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         csum_q     <= '0;
         idle_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         csum_q     <= csum_d;
         idle_q     <= idle_d;
         done_q     <= done_d;
         err_q      <= err_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         head_q     <= head_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign byte_data   = head_q[7:0];
   assign byte_last   = head_q[8];
   assign byte_valid  = valid_q;
   assign sync_locked = (state_q == PAYLOAD);
   assign frame_done  = done_q;
   assign frame_err   = err_q;
   assign overflow    = overflow_q;

endmodule
